time_counter: RTL

Current-time keeper of the alarm clock. It counts `one_second` pulses into minutes and keeps hours and minutes as four BCD digits in 24-hour format (00:00–23:59). It consumes `load_new_c` and `reset_count` from the control FSM and the keypad-entered digits, and drives the current-time digits to the display driver and the alarm comparator.

---
 rtl/alarm_clock_pkg.sv | 16 +
 rtl/time_counter_if.sv | 40 ++++
 rtl/bcd_digit_cnt.sv | 34 +++
 rtl/time_counter.sv | 98 +++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared constants for the alarm clock time keeper: BCD digit width,
// per-digit limits and the default seconds-per-minute count.
package alarm_clock_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t MAX_MS_HR      = 4'd2;
    localparam bcd_t MAX_LS_HR_AT_2 = 4'd3;
    localparam bcd_t MAX_MS_MIN     = 4'd5;
    localparam bcd_t MAX_BCD        = 4'd9;

    localparam int TICKS_PER_MIN_DEFAULT = 60;

endpackage

// File: rtl/time_counter_if.sv
// Control/keypad inputs and current-time outputs of the time keeper.
// There is no valid/ready handshake here: every input is a level that is
// sampled on each rising clock edge, and every output is a register.
interface time_counter_if;
    import alarm_clock_pkg::*;

    logic one_second;
    logic reset_count;
    logic load_new_c;
    bcd_t new_current_time_ms_hr;
    bcd_t new_current_time_ls_hr;
    bcd_t new_current_time_ms_min;
    bcd_t new_current_time_ls_min;
    bcd_t current_time_ms_hr;
    bcd_t current_time_ls_hr;
    bcd_t current_time_ms_min;
    bcd_t current_time_ls_min;
    logic minute_tick;
    logic load_err;

    // Control side: drives the pulses and keypad digits, observes the time.
    modport master (
        output one_second, reset_count, load_new_c,
        output new_current_time_ms_hr, new_current_time_ls_hr,
        output new_current_time_ms_min, new_current_time_ls_min,
        input  current_time_ms_hr, current_time_ls_hr,
        input  current_time_ms_min, current_time_ls_min,
        input  minute_tick, load_err
    );

    // Time keeper side.
    modport slave (
        input  one_second, reset_count, load_new_c,
        input  new_current_time_ms_hr, new_current_time_ls_hr,
        input  new_current_time_ms_min, new_current_time_ls_min,
        output current_time_ms_hr, current_time_ls_hr,
        output current_time_ms_min, current_time_ls_min,
        output minute_tick, load_err
    );
endinterface

// File: rtl/bcd_digit_cnt.sv
// One BCD digit: counts 0..max_val, wrapping to 0, with synchronous clear
// and parallel load. terminal_count flags that the digit sits at its max,
// so the next enabled step wraps and carries into the next digit.
module bcd_digit_cnt
    import alarm_clock_pkg::*;
(
    input  logic clock,
    input  logic clr,
    input  logic en,
    input  logic load,
    input  bcd_t load_val,
    input  bcd_t max_val,
    output bcd_t count,
    output logic terminal_count
);

    // Clear beats load beats count; >= wraps any out-of-range value safely.
    always_ff @(posedge clock) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (count >= max_val) begin
                count <= '0;
            end else begin
                count <= count + 4'd1;
            end
        end
    end

    assign terminal_count = (count == max_val);

endmodule

// File: rtl/time_counter.sv
// Current-time keeper: counts one_second pulses into minutes and holds
// HH:MM as four chained BCD digits in 24-hour format.
module time_counter
    import alarm_clock_pkg::*;
#(
    parameter int TICKS_PER_MIN = TICKS_PER_MIN_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    time_counter_if.slave bus
);

    localparam logic [5:0] SEC_MAX = 6'(TICKS_PER_MIN - 1);

    logic [5:0] sec_cnt;
    logic       load_ok;
    logic       do_load;
    logic       advance;
    logic       ls_min_tc, ms_min_tc, ls_hr_tc, ms_hr_tc;
    logic       en_ms_min, en_hr, en_ms_hr;
    bcd_t       ls_hr_max;

    // A load is accepted only if every digit is in range and hour <= 23.
    always_comb begin
        load_ok = (bus.new_current_time_ms_hr  <= MAX_MS_HR)  &&
                  (bus.new_current_time_ls_hr  <= MAX_BCD)    &&
                  (bus.new_current_time_ms_min <= MAX_MS_MIN) &&
                  (bus.new_current_time_ls_min <= MAX_BCD);
        if ((bus.new_current_time_ms_hr == MAX_MS_HR) &&
            (bus.new_current_time_ls_hr > MAX_LS_HR_AT_2)) begin
            load_ok = 1'b0;
        end
    end

    assign do_load = bus.load_new_c && load_ok;

    // A minute step happens only on the last tick of the minute, and only
    // when neither a load nor a seconds clear claims the cycle.
    assign advance = !bus.load_new_c && !bus.reset_count &&
                     bus.one_second && (sec_cnt == SEC_MAX);

    assign en_ms_min = advance && ls_min_tc;
    assign en_hr     = en_ms_min && ms_min_tc;
    assign en_ms_hr  = en_hr && ls_hr_tc;
    assign ls_hr_max = (bus.current_time_ms_hr == MAX_MS_HR) ? MAX_LS_HR_AT_2 : MAX_BCD;

    // Seconds counter plus the registered minute_tick / load_err pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            sec_cnt         <= '0;
            bus.minute_tick <= 1'b0;
            bus.load_err    <= 1'b0;
        end else begin
            bus.minute_tick <= 1'b0;
            bus.load_err    <= 1'b0;
            if (bus.load_new_c) begin
                sec_cnt      <= '0;
                bus.load_err <= !load_ok;
            end else if (bus.reset_count) begin
                sec_cnt <= '0;
            end else if (bus.one_second) begin
                if (sec_cnt == SEC_MAX) begin
                    sec_cnt         <= '0;
                    bus.minute_tick <= 1'b1;
                end else begin
                    sec_cnt <= sec_cnt + 6'd1;
                end
            end
        end
    end

    bcd_digit_cnt u_ls_min (
        .clock(clock), .clr(reset), .en(advance), .load(do_load),
        .load_val(bus.new_current_time_ls_min), .max_val(MAX_BCD),
        .count(bus.current_time_ls_min), .terminal_count(ls_min_tc)
    );

    bcd_digit_cnt u_ms_min (
        .clock(clock), .clr(reset), .en(en_ms_min), .load(do_load),
        .load_val(bus.new_current_time_ms_min), .max_val(MAX_MS_MIN),
        .count(bus.current_time_ms_min), .terminal_count(ms_min_tc)
    );

    bcd_digit_cnt u_ls_hr (
        .clock(clock), .clr(reset), .en(en_hr), .load(do_load),
        .load_val(bus.new_current_time_ls_hr), .max_val(ls_hr_max),
        .count(bus.current_time_ls_hr), .terminal_count(ls_hr_tc)
    );

    // ms_hr advances only when the hour units wrap; at 23:59 both hour
    // digits sit at their terminal counts and wrap together to 00.
    bcd_digit_cnt u_ms_hr (
        .clock(clock), .clr(reset), .en(en_ms_hr), .load(do_load),
        .load_val(bus.new_current_time_ms_hr), .max_val(MAX_MS_HR),
        .count(bus.current_time_ms_hr), .terminal_count(ms_hr_tc)
    );

endmodule
